// File: rtl/cardinal_nic_vcq_if.sv
// Bundle of the processor bus and the router port of cardinal_nic_vcq.
// The "master" modport is the surrounding system (processor plus router),
// and the "slave" modport is the NIC itself.
// Packets and data words use MSB-first numbering [0:PACKET_SIZE-1].
// Bit 0 of a packet is the virtual-channel bit.
interface cardinal_nic_vcq_if #(
    parameter int PACKET_SIZE = 64
) ();
    // processor side
    logic [1:0]             addr;
    logic [0:PACKET_SIZE-1] d_in;
    logic [0:PACKET_SIZE-1] d_out;
    logic                   nicEn;
    logic                   nicEnWr;
    // router side
    logic                   net_so;
    logic                   net_ro;
    logic [0:PACKET_SIZE-1] net_do;
    logic                   net_polarity;
    logic                   net_si;
    logic                   net_ri;
    logic [0:PACKET_SIZE-1] net_di;

    modport master (
        output addr, d_in, nicEn, nicEnWr,
        output net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );

    modport slave (
        input  addr, d_in, nicEn, nicEnWr,
        input  net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/cardinal_nic_vcq.sv
// cardinal_nic_vcq: NIC between a processor and one Cardinal ring router port.
// - Three FIFOs of FIFO_DEPTH entries: input (from router), VC0 out, VC1 out.
// - Injection is gated by ring polarity: only the VC equal to net_polarity
//   may send in a given cycle.
// - Memory-mapped processor access:
//   00 in-data, 01 in-status, 10 out-data (write), 11 out-status.
// Optional feature macro: NIC_STATS_EN.
//   When it is defined, the status words carry occupancies and an 8-bit
//   saturating drop counter.
//   When it is undefined, those fields read 0 and the counter does not exist.
module cardinal_nic_vcq #(
    parameter int PACKET_SIZE = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    cardinal_nic_vcq_if.slave     bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int NQ    = 3;
    localparam int Q_IN  = 0;
    localparam int Q_VC0 = 1;
    localparam int Q_VC1 = 2;

    // Per-queue control and status, indexed by Q_IN/Q_VC0/Q_VC1.
    logic                   q_push  [NQ];
    logic                   q_pop   [NQ];
    logic [0:PACKET_SIZE-1] q_wdata [NQ];
    logic [0:PACKET_SIZE-1] q_head  [NQ];
    logic [CW-1:0]          q_count [NQ];
    logic                   q_full  [NQ];
    logic                   q_empty [NQ];

    genvar gi;
    generate
        for (gi = 0; gi < NQ; gi++) begin : g_queue
            logic [0:PACKET_SIZE-1] mem_reg [FIFO_DEPTH];
            logic [AW-1:0]          wr_ptr_reg;
            logic [AW-1:0]          rd_ptr_reg;
            logic [CW-1:0]          count_reg;
            logic [CW-1:0]          count_next;

            // Occupancy update.
            // Callers guarantee no push when full and no pop when empty.
            always_comb begin
                count_next = count_reg;
                case ({q_push[gi], q_pop[gi]})
                    2'b10:   count_next = count_reg + CW'(1);
                    2'b01:   count_next = count_reg - CW'(1);
                    default: count_next = count_reg;
                endcase
            end

            // Storage write.
            // Not reset, because contents are meaningless while count is 0.
            always_ff @(posedge clk) begin
                if (q_push[gi]) begin
                    mem_reg[wr_ptr_reg] <= q_wdata[gi];
                end
            end

            // Pointers wrap naturally since FIFO_DEPTH is a power of two.
            // Reset flushes the queue.
            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (q_push[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    if (q_pop[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    count_reg <= count_next;
                end
            end

            assign q_head[gi]  = mem_reg[rd_ptr_reg];
            assign q_count[gi] = count_reg;
            assign q_full[gi]  = (count_reg == CW'(FIFO_DEPTH));
            assign q_empty[gi] = (count_reg == '0);
        end
    endgenerate

    logic rd_en;
    logic wr_en;
    logic out_wr;
    logic wr_vc;
    logic drop;
    logic inj_vc;
    logic send;
    logic overflow_reg;

    // Decode processor accesses and the router handshakes into queue push/pop strobes.
    always_comb begin
        rd_en  = bus.nicEn & ~bus.nicEnWr;
        wr_en  = bus.nicEn & bus.nicEnWr;
        out_wr = wr_en && (bus.addr == 2'b10);
        wr_vc  = bus.d_in[0];
        // A full target queue drops the write.
        // A same-cycle injection pop does not rescue it.
        drop   = out_wr && (wr_vc ? q_full[Q_VC1] : q_full[Q_VC0]);

        inj_vc = bus.net_polarity;
        send   = bus.net_ro & ~(inj_vc ? q_empty[Q_VC1] : q_empty[Q_VC0]);

        q_wdata[Q_IN]  = bus.net_di;
        q_wdata[Q_VC0] = bus.d_in;
        q_wdata[Q_VC1] = bus.d_in;

        q_push[Q_IN]   = bus.net_si & ~q_full[Q_IN];
        q_push[Q_VC0]  = out_wr & ~wr_vc & ~q_full[Q_VC0];
        q_push[Q_VC1]  = out_wr &  wr_vc & ~q_full[Q_VC1];

        q_pop[Q_IN]    = rd_en && (bus.addr == 2'b00) && !q_empty[Q_IN];
        q_pop[Q_VC0]   = send & ~inj_vc;
        q_pop[Q_VC1]   = send &  inj_vc;
    end

    assign bus.net_ri = ~q_full[Q_IN];
    assign bus.net_so = send;
    assign bus.net_do = send ? (inj_vc ? q_head[Q_VC1] : q_head[Q_VC0]) : '0;

    // Sticky overflow: set by a drop and cleared by a status read.
    // A drop in the same cycle as the read takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (rd_en && (bus.addr == 2'b11)) begin
            overflow_reg <= 1'b0;
        end
    end

`ifdef NIC_STATS_EN
    logic [7:0] drop_cnt_reg;

    // Saturating drop counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end
`endif

    // Combinational read mux.
    // Idle cycles and the write-only out-data address read as 0.
    always_comb begin
        bus.d_out = '0;
        if (rd_en) begin
            case (bus.addr)
                2'b00: begin
                    if (!q_empty[Q_IN]) bus.d_out = q_head[Q_IN];
                end
                2'b01: begin
                    bus.d_out[PACKET_SIZE-1] = ~q_empty[Q_IN];
`ifdef NIC_STATS_EN
                    bus.d_out[0:7] = 8'(q_count[Q_IN]);
`endif
                end
                2'b11: begin
                    bus.d_out[PACKET_SIZE-1] = q_full[Q_VC0] | q_full[Q_VC1];
                    bus.d_out[PACKET_SIZE-2] = q_full[Q_VC0];
                    bus.d_out[PACKET_SIZE-3] = q_full[Q_VC1];
                    bus.d_out[PACKET_SIZE-4] = overflow_reg;
`ifdef NIC_STATS_EN
                    bus.d_out[0:7]   = 8'(q_count[Q_VC0]);
                    bus.d_out[8:15]  = 8'(q_count[Q_VC1]);
                    bus.d_out[16:23] = drop_cnt_reg;
`endif
                end
                default: bus.d_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_cardinal_nic_vcq.sv
// Testbench for cardinal_nic_vcq.
// Stimulus pushes expected read data and expected injected packets into
// queues. A negedge monitor pops and compares whenever the DUT presents a
// read or an injection.
// Build with NIC_STATS_EN defined to also check the statistics fields.
module tb_cardinal_nic_vcq;
    localparam int P = 64;
    localparam int D = 4;
`ifdef NIC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    logic [0:P-1] exp_rd   [$];
    string        exp_name [$];
    logic [0:P-1] exp_vc0  [$];
    logic [0:P-1] exp_vc1  [$];

    cardinal_nic_vcq_if #(.PACKET_SIZE(P)) bus ();

    cardinal_nic_vcq #(.PACKET_SIZE(P), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ring polarity toggles every cycle.
    initial begin
        bus.net_polarity = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.net_polarity = ~bus.net_polarity;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [0:P-1] got, input logic [0:P-1] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b required %b", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got unexpected output required none", name);
    endtask

    // The VC bit is bit 0 (leftmost in MSB-first numbering).
    // It mirrors the parity of n, so even n go to VC0 and odd n to VC1.
    function automatic logic [0:P-1] pkt(input int unsigned n);
        logic [0:P-1] p;
        p = P'(n);
        p[0] = n[0];
        return p;
    endfunction

    function automatic logic [0:P-1] st01(input bit ne, input int unsigned occ);
        logic [0:P-1] s;
        s = '0;
        s[P-1] = ne;
        if (STATS) s[0:7] = 8'(occ);
        return s;
    endfunction

    function automatic logic [0:P-1] st11(input bit f0, input bit f1, input bit ov,
                                          input int unsigned o0, input int unsigned o1,
                                          input int unsigned dr);
        logic [0:P-1] s;
        s = '0;
        s[P-1] = f0 | f1;
        s[P-2] = f0;
        s[P-3] = f1;
        s[P-4] = ov;
        if (STATS) begin
            s[0:7]   = 8'(o0);
            s[8:15]  = 8'(o1);
            s[16:23] = 8'(dr);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [1:0] a, input logic [0:P-1] exp, input string name);
        bus.addr    = a;
        bus.nicEn   = 1'b1;
        bus.nicEnWr = 1'b0;
        exp_rd.push_back(exp);
        exp_name.push_back(name);
        tick();
        bus.nicEn   = 1'b0;
    endtask

    task automatic cpu_write(input logic [0:P-1] data);
        bus.addr    = 2'b10;
        bus.d_in    = data;
        bus.nicEn   = 1'b1;
        bus.nicEnWr = 1'b1;
        tick();
        bus.nicEn   = 1'b0;
        bus.nicEnWr = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && (exp_vc0.size() + exp_vc1.size()) != 0; i++) tick();
        check(name, P'(exp_vc0.size() + exp_vc1.size()), '0);
    endtask

    // Monitor: compares every read and every injected packet with the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.nicEn && !bus.nicEnWr) begin
                if (exp_rd.size() == 0) fail_now("rd_unexpected");
                else check(exp_name.pop_front(), bus.d_out, exp_rd.pop_front());
            end
            if (bus.net_so) begin
                if (!bus.net_ro) fail_now("so_without_ro");
                check_bit("so_vc_is_pol", bus.net_do[0], bus.net_polarity);
                if (bus.net_polarity) begin
                    if (exp_vc1.size() == 0) fail_now("so_unexpected_vc1");
                    else check("so_data_vc1", bus.net_do, exp_vc1.pop_front());
                end else begin
                    if (exp_vc0.size() == 0) fail_now("so_unexpected_vc0");
                    else check("so_data_vc0", bus.net_do, exp_vc0.pop_front());
                end
            end
        end
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.addr = 2'b00;
        bus.d_in = '0;
        bus.nicEn = 1'b0;
        bus.nicEnWr = 1'b0;
        bus.net_ro = 1'b0;
        bus.net_si = 1'b0;
        bus.net_di = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;

        // Reset state
        check_bit("reset_net_ri", bus.net_ri, 1'b1);
        check("reset_idle_dout", bus.d_out, '0);
        cpu_read(2'b01, '0, "reset_rd01");
        cpu_read(2'b11, '0, "reset_rd11");
        bus.net_ro = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_bit("reset_net_so", bus.net_so, 1'b0);
            tick();
        end
        bus.net_ro = 1'b0;

        // Ejection: fill the input queue, then push once more while it is full
        for (int i = 0; i < 4; i++) begin
            bus.net_si = 1'b1;
            bus.net_di = P'(i);
            tick();
        end
        bus.net_di = P'(99);
        #1;
        check_bit("in_full_net_ri", bus.net_ri, 1'b0);
        tick();
        bus.net_si = 1'b0;
        bus.addr = 2'b00;
        #1;
        check("idle_dout_nonempty", bus.d_out, '0);
        cpu_read(2'b01, st01(1'b1, 4), "in_status_full");
        for (int i = 0; i < 4; i++) cpu_read(2'b00, P'(i), $sformatf("in_data_%0d", i));
        cpu_read(2'b01, st01(1'b0, 0), "in_status_empty");
        cpu_read(2'b00, '0, "in_data_empty");
        cpu_read(2'b10, '0, "out_data_reads_0");
        #1;
        check_bit("in_drained_net_ri", bus.net_ri, 1'b1);

        // Injection: two packets per VC, each VC only on its own polarity
        cpu_write(pkt(2)); exp_vc0.push_back(pkt(2));
        cpu_write(pkt(3)); exp_vc1.push_back(pkt(3));
        cpu_write(pkt(4)); exp_vc0.push_back(pkt(4));
        cpu_write(pkt(5)); exp_vc1.push_back(pkt(5));
        bus.net_ro = 1'b1;
        wait_drain("drain_mixed", 20);
        bus.net_ro = 1'b0;

        // Overflow: 5 writes to VC0, where the last one is dropped
        for (int i = 0; i < 5; i++) begin
            cpu_write(pkt(10 + 2 * i));
            if (i < 4) exp_vc0.push_back(pkt(10 + 2 * i));
        end
        cpu_read(2'b11, st11(1'b1, 1'b0, 1'b1, 4, 0, 1), "ovf_status");
        cpu_read(2'b11, st11(1'b1, 1'b0, 1'b0, 4, 0, 1), "ovf_sticky_cleared");
        bus.net_ro = 1'b1;
        wait_drain("drain_vc0", 20);
        bus.net_ro = 1'b0;
        cpu_read(2'b11, st11(1'b0, 1'b0, 1'b0, 0, 0, 1), "vc0_drained_status");

        // Back-pressure: load VC1 and hold net_ro low, then release it
        for (int i = 0; i < 4; i++) begin
            cpu_write(pkt(7 + 2 * i));
            exp_vc1.push_back(pkt(7 + 2 * i));
        end
        cpu_read(2'b11, st11(1'b0, 1'b1, 1'b0, 0, 4, 1), "vc1_full_status");
        for (int i = 0; i < 10; i++) begin
            #1;
            check_bit("ro_low_net_so", bus.net_so, 1'b0);
            tick();
        end
        bus.net_ro = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_bit("ro_high_so_on_pol1", bus.net_so,
                      bus.net_polarity && (exp_vc1.size() != 0));
            tick();
        end
        check("drain_vc1", P'(exp_vc1.size()), '0);
        bus.net_ro = 1'b0;

        // Reset mid-operation with 3 entries in every queue
        for (int i = 0; i < 3; i++) begin
            bus.net_si = 1'b1;
            bus.net_di = P'(40 + i);
            tick();
        end
        bus.net_si = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_write(pkt(20 + 2 * i));
            cpu_write(pkt(21 + 2 * i));
        end
        cpu_read(2'b01, st01(1'b1, 3), "pre_reset_in_status");
        cpu_read(2'b11, st11(1'b0, 1'b0, 1'b0, 3, 3, 1), "pre_reset_out_status");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.net_ro = 1'b1;
        #1;
        check_bit("post_reset_net_ri", bus.net_ri, 1'b1);
        check_bit("post_reset_net_so", bus.net_so, 1'b0);
        cpu_read(2'b01, '0, "post_reset_rd01");
        cpu_read(2'b11, '0, "post_reset_rd11");
        cpu_read(2'b00, '0, "post_reset_rd00");
        for (int i = 0; i < 6; i++) begin
            #1;
            check_bit("post_reset_no_stale", bus.net_so, 1'b0);
            tick();
        end
        bus.net_ro = 1'b0;

        tick();
        check("reads_all_seen", P'(exp_rd.size()), '0);
        check("sends_all_seen", P'(exp_vc0.size() + exp_vc1.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
